// File: rtl/a1csa_seq_ctrl_pkg.sv
// Shared definitions for the a1csa sequential controller.
// Holds the FSM state encoding, the slice-count derivation, the counter width
// helper and the parameter legality check used at elaboration time.
package a1csa_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of K-bit slices in an N-bit operand.
  function automatic int unsigned nslice(input int unsigned n, input int unsigned k);
    return n / k;
  endfunction

  // Slice counter width; never narrower than one bit, even for a single slice.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned k);
    int unsigned w;
    w = $clog2(n / k);
    return (w < 1) ? 1 : w;
  endfunction

  // Operand width must be a non-zero multiple of a slice at least two bits wide.
  function automatic bit params_ok(input int unsigned n, input int unsigned k);
    return (k >= 2) && (n >= k) && ((n % k) == 0);
  endfunction

endpackage

// File: rtl/a1csa_seq_ctrl_slice.sv
// a1cs_slice: combinational add-one carry-select slice.
// Ports:
//   x, y : K-bit operand slices
//   sel  : incoming inter-slice carry, selects the add-one variant
//   r    : selected K-bit slice result
//   co   : carry out of this slice given sel
module a1cs_slice #(
  parameter int unsigned K = 4
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         sel,
  output logic [K-1:0] r,
  output logic         co
);

  logic [K:0]   s0;
  logic [K-1:0] s1;
  logic         all_ones;

  always_comb begin
    s0       = {1'b0, x} + {1'b0, y};
    s1       = '0;
    // all_ones tracks &s0[j-1:0]; empty prefix is 1 so bit 0 is inverted.
    all_ones = 1'b1;
    for (int j = 0; j < K; j++) begin
      s1[j]    = s0[j] ^ all_ones;
      all_ones = all_ones & s0[j];
    end
    r  = sel ? s1 : s0[K-1:0];
    // Add-one only carries out when the plain sum slice is all ones.
    co = s0[K] | (sel & all_ones);
  end

endmodule

// File: rtl/a1csa_seq_ctrl.sv
// a1csa_seq_ctrl: multi-cycle add-one carry-select adder sequencer.
// Accepts an N-bit operand pair and processes it K bits per cycle through a
// single reused a1cs_slice, with a registered carry between slices.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
module a1csa_seq_ctrl
  import a1csa_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NSLICE = nslice(N, K);
  localparam int unsigned CW     = cnt_width(N, K);

  if (!params_ok(N, K)) begin : g_bad_params
    $fatal(1, "a1csa_seq_ctrl: N must be a multiple of K and K must be at least 2");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q, b_q, sum_q;
  logic          c_q, cout_q;

  logic          accept;
  logic          last;
  int unsigned   base;
  logic [K-1:0]  slice_r;
  logic          slice_co;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (cnt_q == CW'(NSLICE - 1));
  assign base   = 32'(cnt_q) * K;

  a1cs_slice #(
    .K(K)
  ) u_slice (
    .x  (a_q[base +: K]),
    .y  (b_q[base +: K]),
    .sel(c_q),
    .r  (slice_r),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      a_q    <= a;
      b_q    <= b;
      c_q    <= cin;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state_q == RUN) begin
      sum_q[base +: K] <= slice_r;
      c_q              <= slice_co;
      if (last) begin
        cout_q <= slice_co;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_a1csa_seq_ctrl.sv
module tb_a1csa_seq_ctrl;

  localparam int N  = 16;
  localparam int K  = 4;
  localparam int NS = N / K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  a1csa_seq_ctrl #(
    .N(N),
    .K(K)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an operation is "active" from accept until the result
  // handshake; m_age counts cycles since accept (1 = first cycle after it).
  bit           m_active = 1'b0;
  int           m_age    = 0;
  logic [N:0]   m_res    = '0;
  logic [N:0]   m_last   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_last   <= '0;
    end else if (!m_active) begin
      if (in_valid === 1'b1) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_res    <= {1'b0, a} + {1'b0, b} + (N + 1)'(cin);
        m_last   <= '0;
      end
    end else if (m_age == NS + 1) begin
      if (out_ready === 1'b1) m_active <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == NS) m_last <= m_res;
    end
  end

  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = m_active && (m_age == NS + 1);
    chk("in_ready", in_ready, !m_active);
    chk("out_valid", out_valid, exp_ov);
    if (!m_active || exp_ov) begin
      chk("sum", sum, m_last[N-1:0]);
      chk("cout", cout, m_last[N]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc,
                    input logic [N-1:0] es, input logic ec, input int stall);
    int lat;
    int guard;
    guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_op", in_ready, 1'b1);
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, NS + 1);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a = ~ta;
      b = 16'h0F0F;
      cin = ~tc;
      tick();
      chk("stall_sum", sum, es);
      chk("stall_cout", cout, ec);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_sum", sum, es);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    int n_acc;
    int guard;
    bit pair;
    logic [N-1:0] pa [2];
    logic [N-1:0] pb [2];

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, 16'h0000);
    chk("reset_cout", cout, 1'b0);
    rst_n = 1'b1;
    tick();

    op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 0);
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3);

    // Reset in the middle of RUN.
    a = 16'hABCD;
    b = 16'h1357;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_sum", sum, 16'h0000);
    chk("midrst_cout", cout, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);

    // Back-to-back with alternating operand pairs.
    pa[0] = 16'hA5A5; pb[0] = 16'h5A5B;
    pa[1] = 16'h8001; pb[1] = 16'hFFFE;
    pair = 1'b0;
    n_acc = 0;
    last_acc = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = pa[0];
    b = pb[0];
    cin = 1'b1;
    for (int i = 0; i < 6 * 8 + 2; i++) begin
      if (in_ready) begin
        if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, NS + 2);
        last_acc = cyc;
        n_acc++;
        tick();
        pair = ~pair;
        a = pa[pair];
        b = pb[pair];
        cin = ~cin;
      end else begin
        tick();
      end
    end
    chk("b2b_accepts", n_acc, 9);
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("b2b_drain", in_ready, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = N'($urandom);
      b   = N'($urandom);
      cin = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
